mips_harvard_bus_bridge: RTL and testbench
==========================================

Name: mips_harvard_bus_bridge

Overview:
- Parametrised bridge that lets the Harvard CPU core (separate instruction and data ports) run against a single shared memory bus.
- The bus is Avalon-style with waitrequest.
- Arbitrates instruction fetches and data accesses, sequences the bus handshake, and returns read data with a one-cycle acknowledge per request.
- Sits between the CPU core and the testbench RAM model.
- Generalises the core's fixed 32-bit, zero-wait, dual-port memory assumption to a configurable width and a stalling bus.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; must be a multiple of 8 and at least 16; BE_W = DATA_W/8.
- DATA_FIRST, 1, grant priority when both ports request in the same cycle: 1 = data first, 0 = instruction first.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_read  in  1  instruction fetch request; held high until instr_ack.
- instr_address  in  ADDR_W  fetch address.
- instr_readdata  out  DATA_W  fetched word; valid only while instr_ack=1.
- instr_ack  out  1  one-cycle completion pulse for the fetch.
- data_read  in  1  load request; held high until data_ack.
- data_write  in  1  store request; held high until data_ack; never asserted together with data_read.
- data_address  in  ADDR_W  load/store address.
- data_byteenable  in  BE_W  byte lanes for the store or load.
- data_writedata  in  DATA_W  store data.
- data_readdata  out  DATA_W  load result; valid only while data_ack=1.
- data_ack  out  1  one-cycle completion pulse for the load or store.
- bus_address  out  ADDR_W  word-aligned bus address (low log2(BE_W) bits forced to 0).
- bus_read  out  1  bus read strobe.
- bus_write  out  1  bus write strobe.
- bus_byteenable  out  BE_W  bus byte lanes; all ones for fetches.
- bus_writedata  out  DATA_W  bus write data.
- bus_waitrequest  in  1  slave stall.
- bus_readdata  in  DATA_W  valid in the cycle after a read is accepted.

Behaviour:
- Reset: on a clock edge with reset=1, state becomes IDLE. bus_read, bus_write, instr_ack and data_ack are 0. bus_address, bus_byteenable, bus_writedata, instr_readdata and data_readdata are 0. The last-grant flag is cleared.
- FSM states: IDLE, I_REQ, D_REQ, I_RESP, D_RESP.
- IDLE:
  - Only one port requesting: go to I_REQ or D_REQ for that port.
  - Both ports requesting: the DATA_FIRST port wins, unless the last grant went to that port while the other port was waiting; in that case the other port wins (no starvation).
  - The bus strobes and registers are driven from the next cycle. There is no combinational path from CPU request to bus strobe.
- I_REQ / D_REQ:
  - bus_read or bus_write, bus_address, bus_byteenable and bus_writedata are held stable while bus_waitrequest=1.
  - When the cycle is accepted (strobe=1 and waitrequest=0):
    - Read: drop the strobe and go to I_RESP or D_RESP.
    - Write: drop the strobe, pulse data_ack in the next cycle, and return to IDLE.
- I_RESP / D_RESP: bus_readdata is captured into instr_readdata or data_readdata, the matching ack pulses for exactly 1 cycle, and the FSM returns to IDLE.
- Minimum latency:
  - Read: request to ack = 3 cycles (grant, accepted, response).
  - Write: request to ack = 2 cycles.
  - Each waitrequest cycle adds 1.
- CPU stall semantics: the core treats (request & !ack) as stall. The bridge samples request inputs only in IDLE, so address or data changes during a transaction are ignored.
- After an ack, the port's request must be re-evaluated. A request still high in the cycle after its ack is treated as a new transaction.
- Reset mid-transaction: strobes drop at that edge and the transaction is abandoned with no ack. The slave model must tolerate this.
- A data_read and data_write asserted together is illegal. The bridge treats it as a write, and an assertion fires in simulation.

Optional Feature:
- Macro: MIPS_BRIDGE_IBUF_EN.
- When defined, a one-entry instruction buffer (valid bit, tag, word) is added:
  - A fetch whose word-aligned address equals the tag while valid=1 is acked in the cycle after the request, with no bus cycle.
  - The buffer is filled on every completed fetch.
  - The buffer is invalidated by reset and by any accepted data write whose word address equals the tag.
- When undefined, every fetch goes to the bus and the behaviour above is exact.

Decomposition:
- Package mips_bus_pkg:
  - bridge_state_t enum.
  - BUS_BE_W(DATA_W) and BUS_ALIGN_BITS(DATA_W) constant functions.
  - Shared by all future bus-facing wrappers.
- One sub-module, mips_bridge_ibuf (tag compare, fill, invalidate). It is instantiated only under MIPS_BRIDGE_IBUF_EN.

Test Plan:
1. Fetch at 0xBFC00000, waitrequest=0, readdata=0x24020005 → bus_read high for 1 cycle at 0xBFC00000 with byteenable 0xF; instr_ack 3 cycles after request with instr_readdata=0x24020005.
2. Store at 0x00001003 with data 0xDEADBEEF, byteenable 0x8, waitrequest high for 4 cycles → bus_address 0x00001000; all bus signals stable for 4 cycles; data_ack 6 cycles after request.
3. Fetch and load asserted together, DATA_FIRST=1, held continuously → grants D, I, D, I in order; no port starves.
4. Same as 3 with DATA_FIRST=0 → first grant is I.
5. Reset asserted while bus_read is held under waitrequest → bus_read=0 and no ack at the next edge; a fetch after reset completes normally.
6. With MIPS_BRIDGE_IBUF_EN, fetch 0x100 twice → second ack 1 cycle after request with no bus_read. Then store to 0x100 and fetch 0x100 again → bus_read reissued.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared state encoding and width helpers for bus-facing CPU wrappers
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        I_REQ,
        D_REQ,
        I_RESP,
        D_RESP
    } bridge_state_t;

    function automatic int BUS_BE_W(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int BUS_ALIGN_BITS(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mips_bridge_ibuf.sv
// rtl/mips_bridge_ibuf.sv - one-entry instruction buffer: tag compare, fill on fetch, invalidate on store
module mips_bridge_ibuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              inval_i,
    input  logic [ADDR_W-1:0] inval_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] word_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr_i;
            word_q  <= fill_data_i;
        end else if (inval_i && (inval_addr_i == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (lookup_addr_i == tag_q);
    assign word_o = word_q;

endmodule

// File: rtl/mips_harvard_bus_bridge.sv
// rtl/mips_harvard_bus_bridge.sv - Harvard I/D ports onto one waitrequest bus; MIPS_BRIDGE_IBUF_EN adds a fetch buffer
module mips_harvard_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit DATA_FIRST = 1'b1,
    localparam int BE_W      = BUS_BE_W(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    output logic              instr_ack,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [BE_W-1:0]   data_byteenable,
    input  logic [DATA_W-1:0] data_writedata,
    output logic [DATA_W-1:0] data_readdata,
    output logic              data_ack,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_read,
    output logic              bus_write,
    output logic [BE_W-1:0]   bus_byteenable,
    output logic [DATA_W-1:0] bus_writedata,
    input  logic              bus_waitrequest,
    input  logic [DATA_W-1:0] bus_readdata
);

    localparam int ALIGN = BUS_ALIGN_BITS(DATA_W);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << ALIGN) - 1);

    bridge_state_t     state_q;
    logic              starve_q;
    logic              instr_ack_q, data_ack_q;
    logic [DATA_W-1:0] instr_readdata_q, data_readdata_q;
    logic [ADDR_W-1:0] bus_address_q;
    logic              bus_read_q, bus_write_q;
    logic [BE_W-1:0]   bus_byteenable_q;
    logic [DATA_W-1:0] bus_writedata_q;

    logic              i_req_d, d_req_d, d_wins_d;
    logic              ibuf_hit;
    logic [DATA_W-1:0] ibuf_word;

    // A request seen during its own ack cycle is the old one; only a request
    // still high one cycle later counts as a new transaction.
    assign i_req_d = instr_read & ~instr_ack_q;
    assign d_req_d = (data_read | data_write) & ~data_ack_q;

    always_comb begin
        d_wins_d = d_req_d;
        if (i_req_d && d_req_d) begin
            d_wins_d = DATA_FIRST ? !starve_q : starve_q;
        end
    end

`ifdef MIPS_BRIDGE_IBUF_EN
    mips_bridge_ibuf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ibuf (
        .clk          (clk),
        .reset        (reset),
        .lookup_addr_i(instr_address & ~LOW_MASK),
        .fill_i       (state_q == I_RESP),
        .fill_addr_i  (bus_address_q),
        .fill_data_i  (bus_readdata),
        .inval_i      ((state_q == D_REQ) && bus_write_q && !bus_waitrequest),
        .inval_addr_i (bus_address_q),
        .hit_o        (ibuf_hit),
        .word_o       (ibuf_word)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            starve_q         <= 1'b0;
            instr_ack_q      <= 1'b0;
            data_ack_q       <= 1'b0;
            instr_readdata_q <= '0;
            data_readdata_q  <= '0;
            bus_address_q    <= '0;
            bus_read_q       <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_byteenable_q <= '0;
            bus_writedata_q  <= '0;
        end else begin
            instr_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req_d || d_req_d) begin
                        starve_q <= i_req_d && d_req_d && (d_wins_d == DATA_FIRST);
                    end
                    if (d_wins_d) begin
                        state_q          <= D_REQ;
                        bus_address_q    <= data_address & ~LOW_MASK;
                        bus_byteenable_q <= data_byteenable;
                        bus_writedata_q  <= data_write ? data_writedata : '0;
                        bus_write_q      <= data_write;
                        bus_read_q       <= !data_write;
                    end else if (i_req_d && ibuf_hit) begin
                        instr_readdata_q <= ibuf_word;
                        instr_ack_q      <= 1'b1;
                    end else if (i_req_d) begin
                        state_q          <= I_REQ;
                        bus_address_q    <= instr_address & ~LOW_MASK;
                        bus_byteenable_q <= '1;
                        bus_writedata_q  <= '0;
                        bus_read_q       <= 1'b1;
                    end
                end
                I_REQ, D_REQ: begin
                    if (!bus_waitrequest) begin
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        if (bus_write_q) begin
                            data_ack_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= (state_q == I_REQ) ? I_RESP : D_RESP;
                        end
                    end
                end
                I_RESP: begin
                    instr_readdata_q <= bus_readdata;
                    instr_ack_q      <= 1'b1;
                    state_q          <= IDLE;
                end
                D_RESP: begin
                    data_readdata_q <= bus_readdata;
                    data_ack_q      <= 1'b1;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_readdata = instr_readdata_q;
    assign instr_ack      = instr_ack_q;
    assign data_readdata  = data_readdata_q;
    assign data_ack       = data_ack_q;
    assign bus_address    = bus_address_q;
    assign bus_read       = bus_read_q;
    assign bus_write      = bus_write_q;
    assign bus_byteenable = bus_byteenable_q;
    assign bus_writedata  = bus_writedata_q;

    assert property (@(posedge clk) disable iff (reset) !(data_read && data_write));

endmodule

// File: tb/tb_mips_harvard_bus_bridge.sv
// tb/tb_mips_harvard_bus_bridge.sv - directed self-checking bench for mips_harvard_bus_bridge
module tb_mips_harvard_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic        data_read, data_write;
    logic [31:0] data_address;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;

    logic [31:0] instr_readdata, data_readdata, bus_address, bus_writedata;
    logic        instr_ack, data_ack, bus_read, bus_write;
    logic [3:0]  bus_byteenable;

    logic [31:0] alt_instr_readdata, alt_data_readdata, alt_bus_address, alt_bus_writedata;
    logic        alt_instr_ack, alt_data_ack, alt_bus_read, alt_bus_write;
    logic [3:0]  alt_bus_byteenable;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] g1 [4];
    logic [31:0] g0 [4];
    int          n1, n0;

    always #5 clk = ~clk;

    mips_harvard_bus_bridge #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .instr_read(instr_read), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .instr_ack(instr_ack),
        .data_read(data_read), .data_write(data_write), .data_address(data_address),
        .data_byteenable(data_byteenable), .data_writedata(data_writedata),
        .data_readdata(data_readdata), .data_ack(data_ack),
        .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
        .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
        .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata)
    );

    mips_harvard_bus_bridge #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b0)) u_dut_ifirst (
        .clk(clk), .reset(reset),
        .instr_read(instr_read), .instr_address(instr_address),
        .instr_readdata(alt_instr_readdata), .instr_ack(alt_instr_ack),
        .data_read(data_read), .data_write(data_write), .data_address(data_address),
        .data_byteenable(data_byteenable), .data_writedata(data_writedata),
        .data_readdata(alt_data_readdata), .data_ack(alt_data_ack),
        .bus_address(alt_bus_address), .bus_read(alt_bus_read), .bus_write(alt_bus_write),
        .bus_byteenable(alt_bus_byteenable), .bus_writedata(alt_bus_writedata),
        .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_read = 1'b0; instr_address = '0;
        data_read = 1'b0; data_write = 1'b0; data_address = '0;
        data_byteenable = '0; data_writedata = '0;
        bus_waitrequest = 1'b0; bus_readdata = '0;
        tick();
        tick();
        check("rst_bus_read", bus_read, 1'b0);
        check("rst_bus_write", bus_write, 1'b0);
        check("rst_instr_ack", instr_ack, 1'b0);
        check("rst_data_ack", data_ack, 1'b0);
        check("rst_bus_address", bus_address, 32'h0);
        check("rst_bus_be", bus_byteenable, 4'h0);
        check("rst_bus_wdata", bus_writedata, 32'h0);
        check("rst_instr_rdata", instr_readdata, 32'h0);
        check("rst_data_rdata", data_readdata, 32'h0);
        reset = 1'b0;
        tick();

        // Zero-wait fetch: grant, accept, response
        instr_read = 1'b1; instr_address = 32'hBFC0_0000; bus_readdata = 32'h2402_0005;
        tick();
        check("f1_bus_read", bus_read, 1'b1);
        check("f1_bus_addr", bus_address, 32'hBFC0_0000);
        check("f1_bus_be", bus_byteenable, 4'hF);
        check("f1_ack_early", instr_ack, 1'b0);
        tick();
        check("f1_strobe_drop", bus_read, 1'b0);
        check("f1_ack_c2", instr_ack, 1'b0);
        tick();
        check("f1_ack", instr_ack, 1'b1);
        check("f1_rdata", instr_readdata, 32'h2402_0005);
        instr_read = 1'b0;
        tick();
        check("f1_ack_pulse", instr_ack, 1'b0);

        // Store with four waitrequest cycles
        data_write = 1'b1; data_address = 32'h0000_1003;
        data_writedata = 32'hDEAD_BEEF; data_byteenable = 4'h8; bus_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("st_bus_write", bus_write, 1'b1);
            check("st_bus_addr", bus_address, 32'h0000_1000);
            check("st_bus_be", bus_byteenable, 4'h8);
            check("st_bus_wdata", bus_writedata, 32'hDEAD_BEEF);
            check("st_no_ack", data_ack, 1'b0);
            tick();
        end
        bus_waitrequest = 1'b0;
        check("st_still_write", bus_write, 1'b1);
        tick();
        check("st_ack", data_ack, 1'b1);
        check("st_strobe_drop", bus_write, 1'b0);
        data_write = 1'b0;
        tick();
        check("st_ack_pulse", data_ack, 1'b0);

        // Contention, both priorities side by side
        instr_read = 1'b1; instr_address = 32'h0000_0200;
        data_read = 1'b1; data_address = 32'h0000_0300; data_byteenable = 4'hF;
        bus_readdata = 32'h1357_9BDF;
        g1 = '{default: 32'h0};
        g0 = '{default: 32'h0};
        n1 = 0;
        n0 = 0;
        for (int c = 0; c < 40 && (n1 < 4 || n0 < 4); c++) begin
            tick();
            if (bus_read && n1 < 4) begin
                g1[n1] = bus_address;
                n1++;
            end
            if (alt_bus_read && n0 < 4) begin
                g0[n0] = alt_bus_address;
                n0++;
            end
        end
        check("df1_grant_count", n1, 4);
        check("df0_grant_count", n0, 4);
        check("df1_grant0_D", g1[0], 32'h300);
        check("df1_grant1_I", g1[1], 32'h200);
        check("df1_grant2_D", g1[2], 32'h300);
        check("df1_grant3_I", g1[3], 32'h200);
        check("df0_grant0_I", g0[0], 32'h200);
        check("df0_grant1_D", g0[1], 32'h300);
        instr_read = 1'b0;
        data_read = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Reset while a fetch is stalled
        instr_read = 1'b1; instr_address = 32'h0000_0400; bus_waitrequest = 1'b1;
        tick();
        check("rm_bus_read", bus_read, 1'b1);
        tick();
        check("rm_bus_read_held", bus_read, 1'b1);
        reset = 1'b1;
        tick();
        check("rm_strobe_drop", bus_read, 1'b0);
        check("rm_no_ack", instr_ack, 1'b0);
        reset = 1'b0; bus_waitrequest = 1'b0; bus_readdata = 32'h1111_2222;
        tick();
        check("rm_refetch", bus_read, 1'b1);
        check("rm_refetch_addr", bus_address, 32'h0000_0400);
        tick();
        tick();
        check("rm_ack", instr_ack, 1'b1);
        check("rm_rdata", instr_readdata, 32'h1111_2222);
        instr_read = 1'b0;
        tick();

        // Repeat fetch, store to same word, fetch again
        instr_read = 1'b1; instr_address = 32'h0000_0100; bus_readdata = 32'hAAAA_5555;
        tick();
        tick();
        tick();
        check("ib_first_ack", instr_ack, 1'b1);
        instr_read = 1'b0;
        tick();
        instr_read = 1'b1;
        tick();
`ifdef MIPS_BRIDGE_IBUF_EN
        check("ib_hit_ack", instr_ack, 1'b1);
        check("ib_hit_nobus", bus_read, 1'b0);
        check("ib_hit_rdata", instr_readdata, 32'hAAAA_5555);
`else
        check("ib_refetch_bus", bus_read, 1'b1);
        tick();
        tick();
        check("ib_refetch_ack", instr_ack, 1'b1);
        check("ib_refetch_rdata", instr_readdata, 32'hAAAA_5555);
`endif
        instr_read = 1'b0;
        tick();
        data_write = 1'b1; data_address = 32'h0000_0100;
        data_writedata = 32'h0; data_byteenable = 4'hF;
        tick();
        check("ib_st_write", bus_write, 1'b1);
        tick();
        check("ib_st_ack", data_ack, 1'b1);
        data_write = 1'b0;
        tick();
        instr_read = 1'b1; bus_readdata = 32'h1234_5678;
        tick();
        check("ib_inval_bus_read", bus_read, 1'b1);
        check("ib_inval_addr", bus_address, 32'h0000_0100);
        tick();
        tick();
        check("ib_inval_ack", instr_ack, 1'b1);
        check("ib_inval_rdata", instr_readdata, 32'h1234_5678);
        instr_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
